minterm_scan: RTL and testbench

Sequential truth-table extractor for 4-input combinational functions: the inverse of a sum-of-products implementation. On `start` it drives all 16 input combinations onto a function under test, samples the function's output, and builds a 16-bit minterm mask. It then streams the set minterm indices in ascending order over a valid/ready handshake. It sits beside the team's SoP/PoS gate-level blocks as an in-fabric checker and minterm-list generator.

---
 rtl/minterm_pkg.sv | 14 +
 rtl/minterm_scan_prio_enc16.sv | 17 +
 rtl/minterm_scan.sv | 141 ++++++++++++++
 tb/tb_minterm_scan.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/minterm_pkg.sv
// rtl/minterm_pkg.sv - shared types and sizes for the minterm scanner
package minterm_pkg;

  localparam int NIN  = 4;
  localparam int NMIN = 16;
  localparam int CW   = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2
  } state_e;

endpackage

// File: rtl/minterm_scan_prio_enc16.sv
// rtl/minterm_scan_prio_enc16.sv - lowest-set-bit index of a 16-bit vector
module prio_enc16 (
  input  logic [15:0] vec_i,
  output logic [3:0]  idx_o,
  output logic        any_o
);

  // Descending scan so the lowest set bit is the last one written
  always_comb begin
    idx_o = '0;
    any_o = |vec_i;
    for (int k = 15; k >= 0; k--) begin
      if (vec_i[k]) idx_o = 4'(k);
    end
  end

endmodule

// File: rtl/minterm_scan.sv
// rtl/minterm_scan.sv - probes a 4-input function, builds its minterm mask, streams set indices
module minterm_scan
  import minterm_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [NIN-1:0]  probe,
  input  logic            f_in,
  output logic            busy,
  output logic [NMIN-1:0] mask,
  output logic            mask_valid,
  output logic [CW-1:0]   count,
  output logic            m_valid,
  output logic [NIN-1:0]  m_index,
  input  logic            m_ready,
  output logic            done
);

  localparam int HW = $clog2(SETTLE + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(SETTLE - 1);

  state_e          state_q, state_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [NIN-1:0]  probe_q, probe_d;
  logic [NMIN-1:0] mask_q, mask_d;
  logic [NMIN-1:0] rem_q, rem_d;
  logic [CW-1:0]   count_q, count_d;
  logic            mask_valid_q, mask_valid_d;
  logic            done_q, done_d;

  logic            sample;
  logic            xfer;
  logic            rem_any;
  logic [NIN-1:0]  low_idx;
  logic [NMIN-1:0] rem_clr;

  prio_enc16 u_enc (
    .vec_i (rem_q),
    .idx_o (low_idx),
    .any_o (rem_any)
  );

  assign sample  = (state_q == SCAN) && (hold_q == HOLD_LAST);
  assign xfer    = (state_q == EMIT) && m_ready;
  assign rem_clr = rem_q & ~(NMIN'(1) << low_idx);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = SCAN;
      SCAN: if (sample && probe_q == 4'hF) state_d = (|mask_d) ? EMIT : IDLE;
      EMIT: if (xfer && rem_clr == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != IDLE);
    m_valid = (state_q == EMIT) && rem_any;
    m_index = m_valid ? low_idx : '0;
  end

  // Datapath next-state; mask_d carries the final sample into rem on the last edge
  always_comb begin
    hold_d       = hold_q;
    probe_d      = probe_q;
    mask_d       = mask_q;
    rem_d        = rem_q;
    count_d      = count_q;
    mask_valid_d = mask_valid_q;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mask_d       = '0;
          count_d      = '0;
          mask_valid_d = 1'b0;
          probe_d      = '0;
          hold_d       = '0;
        end
      end
      SCAN: begin
        if (sample) begin
          mask_d[probe_q] = f_in;
          count_d         = count_q + CW'(f_in);
          probe_d         = probe_q + 1'b1;
          hold_d          = '0;
          if (probe_q == 4'hF) begin
            rem_d        = mask_d;
            mask_valid_d = 1'b1;
            done_d       = ~|mask_d;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      EMIT: begin
        if (xfer) begin
          rem_d  = rem_clr;
          done_d = (rem_clr == '0);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q       <= '0;
      probe_q      <= '0;
      mask_q       <= '0;
      rem_q        <= '0;
      count_q      <= '0;
      mask_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      probe_q      <= probe_d;
      mask_q       <= mask_d;
      rem_q        <= rem_d;
      count_q      <= count_d;
      mask_valid_q <= mask_valid_d;
      done_q       <= done_d;
    end
  end

  assign probe      = probe_q;
  assign mask       = mask_q;
  assign count      = count_q;
  assign mask_valid = mask_valid_q;
  assign done       = done_q;

endmodule

// File: tb/tb_minterm_scan.sv
// tb/tb_minterm_scan.sv - self-checking bench for minterm_scan
module tb_minterm_scan;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, m_ready, f_in;
  logic [15:0] tt;
  logic [3:0]  probe, m_index;
  logic        busy, mask_valid, m_valid, done;
  logic [15:0] mask;
  logic [4:0]  count;

  logic        start3, ready3, f3;
  logic [3:0]  probe3, m_index3;
  logic        busy3, mask_valid3, m_valid3, done3;
  logic [15:0] mask3;
  logic [4:0]  count3;

  int errors = 0;
  int checks = 0;

  assign f_in = tt[probe];
  assign f3   = probe3[0];

  minterm_scan #(.SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .probe(probe), .f_in(f_in),
    .busy(busy), .mask(mask), .mask_valid(mask_valid), .count(count),
    .m_valid(m_valid), .m_index(m_index), .m_ready(m_ready), .done(done)
  );

  minterm_scan #(.SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .probe(probe3), .f_in(f3),
    .busy(busy3), .mask(mask3), .mask_valid(mask_valid3), .count(count3),
    .m_valid(m_valid3), .m_index(m_index3), .m_ready(ready3), .done(done3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic run_scan(input logic [15:0] tv, input int rmode);
    int exp_q[$];
    int got_q[$];
    int n, cyc, done_at, stalls, stall9;
    logic prev_stall;
    logic [3:0] prev_idx;
    tt = tv;
    n  = 0;
    for (int k = 0; k < 16; k++) if (tv[k]) begin exp_q.push_back(k); n++; end
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_mask_clr", 32'(mask), 32'd0);
    chk("start_count_clr", 32'(count), 32'd0);
    chk("start_mvalid_clr", 32'(mask_valid), 32'd0);
    for (int k = 0; k < 16; k++) begin
      chk("scan_probe", 32'(probe), k);
      chk("scan_busy", 32'(busy), 32'd1);
      chk("scan_m_valid", 32'(m_valid), 32'd0);
      start = 1'($urandom_range(0, 1));
      tick();
    end
    start = 1'b0;
    chk("mask", 32'(mask), 32'(tv));
    chk("count", 32'(count), n);
    chk("mask_valid", 32'(mask_valid), 32'd1);
    chk("probe_end", 32'(probe), 32'd0);
    cyc = 17; done_at = -1; stalls = 0; stall9 = 0;
    prev_stall = 1'b0; prev_idx = '0;
    while (cyc < 300) begin
      if (done) begin done_at = cyc; break; end
      if (prev_stall) begin
        chk("stall_valid", 32'(m_valid), 32'd1);
        chk("stall_idx", 32'(m_index), 32'(prev_idx));
      end
      case (rmode)
        0: m_ready = 1'b1;
        1: m_ready = 1'($urandom_range(0, 1));
        default: begin
          m_ready = 1'b1;
          if (m_valid && m_index == 4'd9 && stall9 < 5) begin
            m_ready = 1'b0;
            stall9++;
          end
        end
      endcase
      if (m_valid && m_ready) got_q.push_back(int'(m_index));
      if (m_valid && !m_ready) stalls++;
      prev_stall = m_valid && !m_ready;
      prev_idx   = m_index;
      start      = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    start   = 1'b0;
    m_ready = 1'b0;
    chk("done_seen", 32'(done_at != -1), 32'd1);
    chk("done_cycle", done_at, 17 + n + stalls);
    chk("n_indices", got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++) chk("index_seq", got_q[i], exp_q[i]);
    chk("done_busy", 32'(busy), 32'd0);
    tick();
    chk("done_pulse", 32'(done), 32'd0);
    chk("idle_m_valid", 32'(m_valid), 32'd0);
    chk("hold_mask_valid", 32'(mask_valid), 32'd1);
    chk("hold_mask", 32'(mask), 32'(tv));
  endtask

  initial begin
    int got3[$];
    int done3_at;
    rst_n = 1'b0; start = 1'b0; m_ready = 1'b0; tt = '0;
    start3 = 1'b0; ready3 = 1'b1;
    tick();
    tick();
    chk("rst_probe", 32'(probe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mask", 32'(mask), 32'd0);
    chk("rst_mask_valid", 32'(mask_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_index", 32'(m_index), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst3_busy", 32'(busy3), 32'd0);
    rst_n = 1'b1;
    tick();

    run_scan(16'h7310, 0);
    run_scan(16'h0000, 0);
    run_scan(16'hFFFF, 0);
    run_scan(16'h7310, 2);
    for (int r = 0; r < 4; r++) run_scan(16'($urandom), 1);

    // SETTLE=3 instance, f = probe[0]
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int c = 1; c <= 48; c++) begin
      chk("s3_probe", 32'(probe3), (c - 1) / 3);
      chk("s3_busy", 32'(busy3), 32'd1);
      if (c == 48) chk("s3_mv_before_last", 32'(mask_valid3), 32'd0);
      tick();
    end
    chk("s3_mask", 32'(mask3), 32'hAAAA);
    chk("s3_count", 32'(count3), 32'd8);
    chk("s3_mask_valid", 32'(mask_valid3), 32'd1);
    chk("s3_m_valid", 32'(m_valid3), 32'd1);
    done3_at = -1;
    for (int c = 49; c < 200; c++) begin
      if (done3) begin done3_at = c; break; end
      if (m_valid3) got3.push_back(int'(m_index3));
      tick();
    end
    chk("s3_done_cycle", done3_at, 57);
    chk("s3_n_indices", got3.size(), 8);
    for (int i = 0; i < 8 && i < got3.size(); i++) chk("s3_index_seq", got3[i], 2 * i + 1);

    // Reset in the middle of a scan
    tt = 16'($urandom);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 && probe != 4'd7; i++) tick();
    chk("mid_reached_p7", 32'(probe), 32'd7);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_probe", 32'(probe), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_mask", 32'(mask), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_mask_valid", 32'(mask_valid), 32'd0);
    chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_m_index", 32'(m_index), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'(busy), 32'd0);
    run_scan(16'($urandom), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
